bpred_pht_ctrl: RTL and testbench

- Controller for the fetch-stage pattern history table (PHT).
- Drives the single-port PHT RAM: index, write enable, write data. Consumes the RAM's combinational read data.
- Arbitrates the one RAM port between fetch-time predictions and queued resolve-time counter updates.
- Updates are read-modify-write of saturating counters, completed in one cycle.

---
 rtl/bpred_pht_ctrl.sv | 139 +++++++++++++
 tb/tb_bpred_pht_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpred_pht_ctrl.sv
// Pattern history table controller: arbitrates the single PHT RAM port between
// fetch-time lookups and a small FIFO of resolve-time saturating-counter updates.
module bpred_pht_ctrl #(
    parameter int unsigned CTRWIDTH  = 2,
    parameter int unsigned LOGINDEX  = 8,
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned LOGQDEPTH = 2,
    parameter int unsigned PCWIDTH   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lookup_valid_in,
    input  logic [PCWIDTH-1:0]  lookup_pc_in,
    output logic                lookup_stall_out,
    output logic                pred_valid_out,
    output logic                pred_taken_out,
    input  logic                upd_valid_in,
    input  logic [PCWIDTH-1:0]  upd_pc_in,
    input  logic                upd_taken_in,
    output logic                upd_ready_out,
    output logic [LOGINDEX-1:0] ram_index_out,
    output logic                ram_we_out,
    output logic [CTRWIDTH-1:0] ram_wdata_out,
    input  logic [CTRWIDTH-1:0] ram_rdata_in
);

    typedef enum logic [1:0] {ArbIdle, ArbLookup, ArbDrain, ArbDrainForced} arb_e;

    localparam logic [LOGQDEPTH:0] QFull = QDEPTH[LOGQDEPTH:0];

    logic [LOGINDEX-1:0]  q_idx_q [QDEPTH];
    logic [QDEPTH-1:0]    q_tkn_q;
    logic [LOGQDEPTH-1:0] head_q, head_d;
    logic [LOGQDEPTH-1:0] tail_q, tail_d;
    logic [LOGQDEPTH:0]   count_q, count_d;
    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;

    logic                 full, empty, push, pop, head_tkn;
    logic [LOGINDEX-1:0]  lookup_idx, upd_idx;
    arb_e                 arb;

    assign lookup_idx = lookup_pc_in[LOGINDEX+1:2];
    assign upd_idx    = upd_pc_in[LOGINDEX+1:2];

    // Upper and byte-offset PC bits are deliberately ignored (aliasing is accepted).
    logic unused_pc;
    assign unused_pc = ^{lookup_pc_in[PCWIDTH-1:LOGINDEX+2], lookup_pc_in[1:0],
                         upd_pc_in[PCWIDTH-1:LOGINDEX+2], upd_pc_in[1:0]};

    assign full          = (count_q == QFull);
    assign empty         = (count_q == '0);
    assign upd_ready_out = !full;
    assign push          = upd_valid_in && !full;
    assign head_tkn      = q_tkn_q[head_q];

    always_comb begin
        if (full) begin
            arb = ArbDrainForced;
        end else if (lookup_valid_in) begin
            arb = ArbLookup;
        end else if (!empty) begin
            arb = ArbDrain;
        end else begin
            arb = ArbIdle;
        end
    end

    always_comb begin
        lookup_stall_out = 1'b0;
        ram_index_out    = '0;
        ram_we_out       = 1'b0;
        ram_wdata_out    = '0;
        pop              = 1'b0;
        unique case (arb)
            ArbLookup: begin
                ram_index_out = lookup_idx;
            end
            ArbDrain, ArbDrainForced: begin
                lookup_stall_out = lookup_valid_in;
                ram_index_out    = q_idx_q[head_q];
                ram_we_out       = 1'b1;
                pop              = 1'b1;
                // Saturating read-modify-write on the asynchronous read data.
                if (head_tkn) begin
                    ram_wdata_out = (ram_rdata_in == '1) ? ram_rdata_in
                                                         : ram_rdata_in + CTRWIDTH'(1);
                end else begin
                    ram_wdata_out = (ram_rdata_in == '0) ? ram_rdata_in
                                                         : ram_rdata_in - CTRWIDTH'(1);
                end
            end
            default: begin
                ram_index_out = '0;
            end
        endcase
    end

    always_comb begin
        head_d  = pop  ? head_q + LOGQDEPTH'(1) : head_q;
        tail_d  = push ? tail_q + LOGQDEPTH'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (LOGQDEPTH+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (LOGQDEPTH+1)'(1);
        end
        pred_valid_d = (arb == ArbLookup);
        pred_taken_d = (arb == ArbLookup) ? ram_rdata_in[CTRWIDTH-1] : pred_taken_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
        end
    end

    // Entry storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx_q[tail_q] <= upd_idx;
            q_tkn_q[tail_q] <= upd_taken_in;
        end
    end

    assign pred_valid_out = pred_valid_q;
    assign pred_taken_out = pred_taken_q;

endmodule

// File: tb/tb_bpred_pht_ctrl.sv
// Scoreboard bench for bpred_pht_ctrl with a behavioural PHT RAM (init 1, async read).
module tb_bpred_pht_ctrl;
    localparam int CW = 2;
    localparam int LI = 8;
    localparam int PW = 64;
    localparam int NE = 1 << LI;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lookup_valid_in = 1'b0;
    logic [PW-1:0] lookup_pc_in = '0;
    logic          lookup_stall_out;
    logic          pred_valid_out, pred_taken_out;
    logic          upd_valid_in = 1'b0;
    logic [PW-1:0] upd_pc_in = '0;
    logic          upd_taken_in = 1'b0;
    logic          upd_ready_out;
    logic [LI-1:0] ram_index_out;
    logic          ram_we_out;
    logic [CW-1:0] ram_wdata_out, ram_rdata_in;

    bpred_pht_ctrl #(
        .CTRWIDTH(CW), .LOGINDEX(LI), .QDEPTH(4), .LOGQDEPTH(2), .PCWIDTH(PW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_valid_in (lookup_valid_in),
        .lookup_pc_in    (lookup_pc_in),
        .lookup_stall_out(lookup_stall_out),
        .pred_valid_out  (pred_valid_out),
        .pred_taken_out  (pred_taken_out),
        .upd_valid_in    (upd_valid_in),
        .upd_pc_in       (upd_pc_in),
        .upd_taken_in    (upd_taken_in),
        .upd_ready_out   (upd_ready_out),
        .ram_index_out   (ram_index_out),
        .ram_we_out      (ram_we_out),
        .ram_wdata_out   (ram_wdata_out),
        .ram_rdata_in    (ram_rdata_in)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] mem [NE];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NE; i++) mem[i] <= CW'(1);
        end else if (ram_we_out) begin
            mem[ram_index_out] <= ram_wdata_out;
        end
    end
    assign ram_rdata_in = mem[ram_index_out];

    typedef struct {
        logic [LI-1:0] idx;
        logic [CW-1:0] val;
    } wr_t;

    wr_t           exp_wr [$];
    logic          exp_pred [$];
    logic [CW-1:0] ref_ctr [NE];   // counters as of pushed updates
    logic [CW-1:0] cmt_ctr [NE];   // counters as of completed writes
    logic          svc_prev = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LI-1:0] idx_of(input logic [PW-1:0] pc);
        return pc[LI+1:2];
    endfunction

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] c, input logic tkn);
        int v;
        v = int'(c) + (tkn ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return CW'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            ref_ctr[i] = CW'(1);
            cmt_ctr[i] = CW'(1);
        end
        exp_wr.delete();
        exp_pred.delete();
    endtask

    always @(negedge clk) begin : mon
        wr_t w;
        logic ep, svc;
        if (reset) begin
            svc_prev = 1'b0;
        end else begin
            chk("pred_valid", pred_valid_out, svc_prev);
            if (pred_valid_out && svc_prev) begin
                if (exp_pred.size() == 0) chk("pred_unexp", 1, 0);
                else begin
                    ep = exp_pred.pop_front();
                    chk("pred_taken", pred_taken_out, ep);
                end
            end
            svc = lookup_valid_in && !lookup_stall_out;
            if (svc) begin
                chk("lk_we", ram_we_out, 0);
                chk("lk_index", ram_index_out, idx_of(lookup_pc_in));
                exp_pred.push_back(cmt_ctr[idx_of(lookup_pc_in)][CW-1]);
            end else if (!ram_we_out) begin
                chk("idle_index", ram_index_out, 0);
            end
            if (ram_we_out) begin
                if (exp_wr.size() == 0) chk("wr_unexp", 1, 0);
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_index", ram_index_out, w.idx);
                    chk("wr_data", ram_wdata_out, w.val);
                    cmt_ctr[w.idx] = w.val;
                end
            end
            if (upd_valid_in && upd_ready_out) begin
                w.idx = idx_of(upd_pc_in);
                w.val = sat(ref_ctr[w.idx], upd_taken_in);
                ref_ctr[w.idx] = w.val;
                exp_wr.push_back(w);
            end
            svc_prev = svc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_upd(input logic [PW-1:0] pc, input logic tkn,
                            output logic rdy0, output logic stl0, output logic we0);
        logic acc;
        acc = 1'b0;
        upd_valid_in = 1'b1;
        upd_pc_in = pc;
        upd_taken_in = tkn;
        rdy0 = 1'b0; stl0 = 1'b0; we0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                rdy0 = upd_ready_out; stl0 = lookup_stall_out; we0 = ram_we_out;
            end
            if (upd_ready_out) begin
                acc = 1'b1;
                break;
            end
            step();
        end
        step();
        chk("upd_accept", acc, 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50 && exp_wr.size() != 0; k++) step();
        chk("drain_done", exp_wr.size() == 0, 1);
    endtask

    task automatic lookup(input logic [PW-1:0] pc);
        lookup_valid_in = 1'b1;
        lookup_pc_in = pc;
        step();
        lookup_valid_in = 1'b0;
        step();
        step();
    endtask

    logic r0, s0, w0;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", upd_ready_out, 1);
        chk("rst_pvalid", pred_valid_out, 0);
        chk("rst_ptaken", pred_taken_out, 0);
        chk("rst_we", ram_we_out, 0);
        chk("rst_stall", lookup_stall_out, 0);
        step();

        lookup(64'h100);

        repeat (3) push_upd(64'h100, 1'b1, r0, s0, w0);
        upd_valid_in = 1'b0;
        wait_drain();
        chk("ctr_sat_hi", cmt_ctr[8'h40], 3);
        lookup(64'h100);

        repeat (2) push_upd(64'h200, 1'b0, r0, s0, w0);
        upd_valid_in = 1'b0;
        wait_drain();
        chk("ctr_sat_lo", cmt_ctr[8'h80], 0);

        // Lookups held high: four updates fill the queue, the fifth forces a drain.
        lookup_valid_in = 1'b1;
        lookup_pc_in = 64'h100;
        for (int i = 0; i < 5; i++) begin
            push_upd(64'h10 + 64'(4 * i), i[0], r0, s0, w0);
            if (i < 4) begin
                chk("fill_ready", r0, 1);
                chk("fill_stall", s0, 0);
            end else begin
                chk("full_ready", r0, 0);
                chk("full_stall", s0, 1);
                chk("full_we", w0, 1);
            end
        end
        upd_valid_in = 1'b0;
        lookup_valid_in = 1'b0;
        wait_drain();
        step();

        push_upd(64'h400, 1'b1, r0, s0, w0);
        upd_valid_in = 1'b0;
        wait_drain();
        lookup(64'h0);

        // Reset with three updates parked behind continuous lookups.
        lookup_valid_in = 1'b1;
        lookup_pc_in = 64'h80;
        for (int i = 0; i < 3; i++) push_upd(64'h20 + 64'(4 * i), 1'b1, r0, s0, w0);
        #2;
        reset = 1'b1;
        lookup_valid_in = 1'b0;
        upd_valid_in = 1'b0;
        model_reset();
        #1;
        chk("arst_pvalid", pred_valid_out, 0);
        chk("arst_ready", upd_ready_out, 1);
        chk("arst_we", ram_we_out, 0);
        chk("arst_stall", lookup_stall_out, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_we", ram_we_out, 0);
            chk("post_rst_ready", upd_ready_out, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end
endmodule
